// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, with sign fix-up and a one-cycle done pulse.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            abort,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     bmag_q, bmag_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed, b_signed, sa, sb, ovf;
    logic [XLEN-1:0]     amag, bmag;
    logic [XLEN:0]       mul_sum, div_tmp, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
    logic [XLEN-1:0]     quot, rem, fix_res;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sa       = a_signed & a[XLEN-1];
        sb       = b_signed & b[XLEN-1];
        amag     = sa ? -a : a;
        bmag     = sb ? -b : b;
        ovf      = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    end

    // acc holds {product} for multiply and {remainder, quotient} for divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_tmp - {1'b0, bmag_q};
        div_next = div_diff[XLEN] ? {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot     = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:    fix_res = acc_q[XLEN-1:0];
            OP_MULH,
            OP_MULHSU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_MULHU:  fix_res = acc_q[2*XLEN-1:XLEN];
            OP_DIV:    fix_res = (sign_a_q ^ sign_b_q) ? -quot : quot;
            OP_REM:    fix_res = sign_a_q ? -rem : rem;
            3'd5:      fix_res = quot;
            default:   fix_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        bmag_d   = bmag_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    op_d     = op;
                    sign_a_d = sa;
                    sign_b_d = sb;
                    acc_d    = {{XLEN{1'b0}}, amag};
                    bmag_d   = bmag;
                    cnt_d    = '0;
                    state_d  = CALC;
                    // op[1] distinguishes REM/REMU from DIV/DIVU
                    if (op[2] && (b == '0)) begin
                        result_d = op[1] ? a : '1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = op[1] ? '0 : a;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1))
                    state_d = FIX;
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            bmag_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            bmag_q   <= bmag_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE) && !abort;
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit at XLEN=32 and XLEN=16.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start32, abort32, ready32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;
    logic        start16, abort16, ready16, done16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, res16;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .abort(abort32), .ready(ready32), .done(done32), .result(res32));
    muldiv_unit #(.XLEN(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
        .abort(abort16), .ready(ready16), .done(done16), .result(res16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one op, then count cycles until done; lat=1 means done in the cycle after accept.
    task automatic run(input bit w16, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit rdy_low);
        @(negedge clk);
        if (w16) begin start16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
        else     begin start32 = 1'b1; op32 = op; a32 = a;       b32 = b;       end
        @(posedge clk);
        lat = 0;
        res = 'x;
        rdy_low = 1'b1;
        while (lat < 80) begin
            @(negedge clk);
            start16 = 1'b0;
            start32 = 1'b0;
            lat++;
            if (w16 ? done16 : done32) begin
                res = w16 ? {16'h0, res16} : res32;
                break;
            end
            if (w16 ? ready16 : ready32) rdy_low = 1'b0;
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic [31:0] mask;
        logic signed [127:0] sa, sb, ua, ub, p;
        logic ovf;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        ua = {96'h0, a & mask};
        ub = {96'h0, b & mask};
        if (w == 32) begin
            sa = {{96{a[31]}}, a};
            sb = {{96{b[31]}}, b};
        end else begin
            sa = {{112{a[15]}}, a[15:0]};
            sb = {{112{b[15]}}, b[15:0]};
        end
        ovf = ((a & mask) == (mask ^ (mask >> 1))) && ((b & mask) == mask);
        p = '0;
        case (op)
            3'd0: p = ua * ub;
            3'd1: begin p = sa * sb; p = p >> w; end
            3'd2: begin p = sa * ub; p = p >> w; end
            3'd3: begin p = ua * ub; p = p >> w; end
            3'd4: if (ub == 0) p = {96'h0, mask}; else if (ovf) p = ua; else p = sa / sb;
            3'd5: if (ub == 0) p = {96'h0, mask}; else p = ua / ub;
            3'd6: if (ub == 0) p = ua; else if (ovf) p = '0; else p = sa % sb;
            default: if (ub == 0) p = ua; else p = ua % ub;
        endcase
        return p[31:0] & mask;
    endfunction

    initial begin
        logic [31:0] res, ra, rb;
        logic [2:0]  rop;
        int          lat, pulses;
        bit          rdy_low, saw_done;

        reset = 1'b1;
        start32 = 1'b0; abort32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start16 = 1'b0; abort16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'h0, ready32}, 32'd1);
        check("reset_done", {31'h0, done32}, 32'd0);
        check("reset_result", res32, 32'h0);
        reset = 1'b0;

        run(0, 3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, rdy_low);
        check("mul_res", res, 32'hFFFF_FFEB);
        check("mul_lat", lat, 32'd34);
        check("mul_ready_low", {31'h0, rdy_low}, 32'd1);
        @(negedge clk);
        check("mul_ready_after", {31'h0, ready32}, 32'd1);

        run(0, 3'd1, 32'h8000_0000, 32'h8000_0000, res, lat, rdy_low);
        check("mulh", res, 32'h4000_0000);
        run(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, rdy_low);
        check("mulhu", res, 32'hFFFF_FFFE);
        run(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, rdy_low);
        check("mulhsu", res, 32'hFFFF_FFFF);
        run(0, 3'd4, 32'hFFFF_FFF9, 32'd2, res, lat, rdy_low);
        check("div_neg", res, 32'hFFFF_FFFD);
        check("div_lat", lat, 32'd34);
        run(0, 3'd6, 32'hFFFF_FFF9, 32'd2, res, lat, rdy_low);
        check("rem_neg", res, 32'hFFFF_FFFF);
        run(0, 3'd5, 32'd100, 32'd7, res, lat, rdy_low);
        check("divu", res, 32'd14);
        run(0, 3'd7, 32'd100, 32'd7, res, lat, rdy_low);
        check("remu", res, 32'd2);

        run(0, 3'd5, 32'd5, 32'd0, res, lat, rdy_low);
        check("divu_by0", res, 32'hFFFF_FFFF);
        check("divu_by0_lat", lat, 32'd1);
        run(0, 3'd6, 32'd5, 32'd0, res, lat, rdy_low);
        check("rem_by0", res, 32'd5);
        check("rem_by0_lat", lat, 32'd1);
        run(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rdy_low);
        check("div_ovf", res, 32'h8000_0000);
        check("div_ovf_lat", lat, 32'd1);
        run(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rdy_low);
        check("rem_ovf", res, 32'h0);
        check("rem_ovf_lat", lat, 32'd1);

        // start while busy must be ignored
        @(negedge clk);
        start32 = 1'b1; op32 = 3'd5; a32 = 32'd100; b32 = 32'd7;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        start32 = 1'b1; op32 = 3'd0; a32 = 32'd3; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        lat = 6;
        while (!done32 && lat < 80) begin @(negedge clk); lat++; end
        check("busy_start_res", res32, 32'd14);
        check("busy_start_lat", lat, 32'd34);

        // abort in CALC cycle 10
        @(negedge clk);
        start32 = 1'b1; op32 = 3'd0; a32 = 32'd5; b32 = 32'd5;
        saw_done = 1'b0;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) begin @(negedge clk); saw_done |= done32; end
        abort32 = 1'b1;
        @(negedge clk);
        abort32 = 1'b0;
        check("abort_ready", {31'h0, ready32}, 32'd1);
        check("abort_done", {31'h0, saw_done | done32}, 32'd0);
        check("abort_result", res32, 32'd14);
        run(0, 3'd0, 32'd3, 32'd4, res, lat, rdy_low);
        check("post_abort_mul", res, 32'd12);

        // reset mid-CALC
        @(negedge clk);
        start32 = 1'b1; op32 = 3'd4; a32 = 32'd99; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_ready", {31'h0, ready32}, 32'd1);
        check("midreset_done", {31'h0, done32}, 32'd0);
        check("midreset_result", res32, 32'h0);
        pulses = 0;
        repeat (40) begin @(negedge clk); if (done32) pulses++; end
        check("midreset_no_done", pulses, 32'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) rb = 32'h0;
            if (i % 6 == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            run(0, rop, ra, rb, res, lat, rdy_low);
            check($sformatf("rand32_op%0d_%h_%h", rop, ra, rb), res, model(rop, ra, rb, 32));
        end
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom & 32'hFFFF;
            rb = $urandom & 32'hFFFF;
            if (i % 6 == 0) rb = 32'h0;
            if (i % 6 == 1) begin ra = 32'h8000; rb = 32'hFFFF; end
            run(1, rop, ra, rb, res, lat, rdy_low);
            check($sformatf("rand16_op%0d_%h_%h", rop, ra, rb), res, model(rop, ra, rb, 16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
